// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck program loader: FSM encoding, error codes, command bytes.
// Optional bracket checking is enabled with BF_LOADER_BRACKET_CHECK_EN.
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TERM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  localparam logic [7:0] CMD_INC   = 8'h2B;
  localparam logic [7:0] CMD_DEC   = 8'h2D;
  localparam logic [7:0] CMD_LEFT  = 8'h3C;
  localparam logic [7:0] CMD_RIGHT = 8'h3E;
  localparam logic [7:0] CMD_OUT   = 8'h2E;
  localparam logic [7:0] CMD_IN    = 8'h2C;
  localparam logic [7:0] CMD_OPEN  = 8'h5B;
  localparam logic [7:0] CMD_CLOSE = 8'h5D;
  localparam logic [7:0] BYTE_EOT  = 8'h00;

endpackage

// File: rtl/bf_cmd_classify.sv
// Combinational classifier: flags command bytes and the two bracket bytes.
module bf_cmd_classify
  import bf_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_cmd,
  output logic       is_open,
  output logic       is_close
);

  always_comb begin
    is_cmd = 1'b0;
    case (byte_in)
      CMD_INC, CMD_DEC, CMD_LEFT, CMD_RIGHT,
      CMD_OUT, CMD_IN, CMD_OPEN, CMD_CLOSE: is_cmd = 1'b1;
      default:                              is_cmd = 1'b0;
    endcase
  end

  assign is_open  = (byte_in == CMD_OPEN);
  assign is_close = (byte_in == CMD_CLOSE);

endmodule

// File: rtl/bf_prog_loader.sv
// Streams ASCII program text into program memory, keeping only command bytes and appending a 0x00 terminator.
// Define BF_LOADER_BRACKET_CHECK_EN to add '[' / ']' balance checking (error codes 1 and 2).
module bf_prog_loader
  import bf_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic              prog_we,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [ADDR_W-1:0] length
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              in_ready_nxt, prog_we_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] prog_addr_nxt, length_nxt;
  logic [7:0]        prog_data_nxt;
  logic [1:0]        error_nxt;

  logic is_cmd, is_open, is_close;
  logic accept, eot, overflow, bad_close, unclosed, store;

  bf_cmd_classify u_classify (
    .byte_in  (in_data),
    .is_cmd   (is_cmd),
    .is_open  (is_open),
    .is_close (is_close)
  );

  assign accept   = in_valid & in_ready;
  assign eot      = accept & (in_data == BYTE_EOT);
  // The last slot is kept free for the terminator.
  assign overflow = accept & is_cmd & (ptr == PTR_LAST);

`ifdef BF_LOADER_BRACKET_CHECK_EN
  logic [ADDR_W-1:0] depth, depth_nxt;

  assign bad_close = accept & is_close & ~overflow & (depth == '0);
  assign unclosed  = eot & (depth != '0);

  always_comb begin
    depth_nxt = depth;
    if (state != ST_LOAD && state != ST_TERM && start)
      depth_nxt = '0;
    else if (store && is_open)
      depth_nxt = depth + 1'b1;
    else if (store && is_close)
      depth_nxt = depth - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) depth <= '0;
    else       depth <= depth_nxt;
  end
`else
  logic unused_bracket;
  assign unused_bracket = is_open ^ is_close;
  assign bad_close      = 1'b0;
  assign unclosed       = 1'b0;
`endif

  assign store = accept & is_cmd & ~overflow & ~bad_close;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (overflow || bad_close || unclosed) state_nxt = ST_ERR;
        else if (eot)                          state_nxt = ST_TERM;
      end
      ST_TERM: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt       = ptr;
    prog_we_nxt   = 1'b0;
    prog_addr_nxt = prog_addr;
    prog_data_nxt = prog_data;
    done_nxt      = done;
    error_nxt     = error;
    length_nxt    = length;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          ptr_nxt   = '0;
          done_nxt  = 1'b0;
          error_nxt = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (store) begin
          prog_we_nxt   = 1'b1;
          prog_addr_nxt = ptr;
          prog_data_nxt = in_data;
          ptr_nxt       = ptr + 1'b1;
        end
        if (overflow)       error_nxt = ERR_OVERFLOW;
        else if (bad_close) error_nxt = ERR_UNMATCHED;
        else if (unclosed)  error_nxt = ERR_UNCLOSED;
      end
      ST_TERM: begin
        prog_we_nxt   = 1'b1;
        prog_addr_nxt = ptr;
        prog_data_nxt = BYTE_EOT;
        length_nxt    = ptr;
        done_nxt      = 1'b1;
      end
      default: ;
    endcase
    // Registered handshake/status track the state being entered so they line up with it.
    in_ready_nxt = (state_nxt == ST_LOAD);
    busy_nxt     = (state_nxt == ST_LOAD) || (state_nxt == ST_TERM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      in_ready  <= 1'b0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= ERR_NONE;
      length    <= '0;
    end else begin
      ptr       <= ptr_nxt;
      in_ready  <= in_ready_nxt;
      prog_we   <= prog_we_nxt;
      prog_addr <= prog_addr_nxt;
      prog_data <= prog_data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      length    <= length_nxt;
    end
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Randomized-backpressure bench for bf_prog_loader with a stream-level reference model.
module tb_bf_prog_loader;

  localparam int AW    = 4;
  localparam int SLOTS = 1 << AW;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, prog_we, busy, done;
  logic [AW-1:0] prog_addr, length;
  logic [7:0]    prog_data;
  logic [1:0]    error;

  bf_prog_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .length    (length)
  );

  always #5 clk = ~clk;

`ifdef BF_LOADER_BRACKET_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int writes_seen = 0;

  // Expected writes, {addr, data}, plus the expected session outcome.
  logic [AW+7:0] exp_q[$];
  int m_err, m_len, m_consumed;
  bit m_ok;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_cmd_b(input logic [7:0] b);
    return b == "+" || b == "-" || b == "<" || b == ">" ||
           b == "." || b == "," || b == "[" || b == "]";
  endfunction

  // Reference: walk the text, producing the write list and the final verdict.
  task automatic model(input byte_q_t s);
    int  ptr = 0;
    int  depth = 0;
    bit  stop = 0;
    logic [AW-1:0] a;
    exp_q.delete();
    m_err = 0; m_len = 0; m_ok = 0; m_consumed = 0;
    for (int i = 0; i < s.size() && !stop; i++) begin
      m_consumed++;
      a = ptr[AW-1:0];
      if (s[i] == 8'h00) begin
        stop = 1;
        if (CHK && depth != 0) m_err = 2;
        else begin
          exp_q.push_back({a, 8'h00});
          m_len = ptr;
          m_ok  = 1;
        end
      end else if (is_cmd_b(s[i])) begin
        if (ptr == SLOTS - 1) begin
          m_err = 3; stop = 1;
        end else if (CHK && s[i] == "]" && depth == 0) begin
          m_err = 1; stop = 1;
        end else begin
          if (s[i] == "[") depth++;
          if (s[i] == "]") depth--;
          exp_q.push_back({a, s[i]});
          ptr++;
        end
      end
    end
  endtask

  function automatic byte_q_t str2q(input string t);
    byte_q_t q;
    for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
    q.push_back(8'h00);
    return q;
  endfunction

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (prog_we) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: addr %0d data %0h with none expected", prog_addr, prog_data);
      end else begin
        check("write_addr", int'(prog_addr), int'(exp_q[0][AW+7:8]));
        check("write_data", int'(prog_data), int'(exp_q[0][7:0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
    check("start_ready", in_ready, 1);
  endtask

  // Feed s with random valid gaps; with rst3 set, reset right after the 3rd accepted byte.
  task automatic run(input byte_q_t s, input bit rst3);
    int idx = 0;
    int cyc = 0;
    bit fire;
    model(s);
    if (rst3) while (exp_q.size() > 3) void'(exp_q.pop_back());
    do_start();
    while (idx < m_consumed && cyc < 600 && !(rst3 && idx == 3)) begin
      in_data  = s[idx];
      in_valid = ($urandom_range(0, 2) != 0);
      fire     = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (fire) idx++;
    end
    if (!(rst3 && idx == 3) && idx < m_consumed) begin
      tests++; fails++;
      $display("FAIL accept_timeout: accepted %0d bytes, required %0d", idx, m_consumed);
    end
    if (rst3) begin
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_we", prog_we, 0);
      check("rst_addr", int'(prog_addr), 0);
      check("rst_data", int'(prog_data), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_length", int'(length), 0);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
        in_data  = "+";
        in_valid = $urandom_range(0, 1);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("rst_pending_writes", exp_q.size(), 0);
    end else begin
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("end_ready", in_ready, 0);
      check("end_busy", busy, 0);
      check("end_done", done, int'(m_ok));
      check("end_error", error, m_err);
      if (m_ok) check("end_length", int'(length), m_len);
      check("pending_writes", exp_q.size(), 0);
    end
  endtask

  logic [7:0] alph [11] = '{"+", "-", "<", ">", ".", ",", "[", "]", "a", " ", 8'h0A};

  initial begin
    int      ws;
    byte_q_t q;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", in_ready, 0);
    check("reset_we", prog_we, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_length", int'(length), 0);
    reset = 1'b0;

    ws = writes_seen;
    run(str2q("+[.+]>-[.-]"), 0);
    check("s1_writes", writes_seen - ws, 12);
    check("s1_length", int'(length), 11);
    check("s1_done", done, 1);

    ws = writes_seen;
    run(str2q({"+ a", 8'h0A, "-"}), 0);
    check("s2_writes", writes_seen - ws, 3);
    check("s2_length", int'(length), 2);

    ws = writes_seen;
    run(str2q("++++++++++++++++"), 0);
    check("ovf_writes", writes_seen - ws, 15);
    check("ovf_error", error, 3);
    check("ovf_ready", in_ready, 0);

`ifdef BF_LOADER_BRACKET_CHECK_EN
    ws = writes_seen;
    run(str2q("]"), 0);
    check("unmatched_writes", writes_seen - ws, 0);
    check("unmatched_error", error, 1);
    ws = writes_seen;
    run(str2q("[+"), 0);
    check("unclosed_writes", writes_seen - ws, 2);
    check("unclosed_error", error, 2);
`else
    ws = writes_seen;
    run(str2q("]"), 0);
    check("close_writes", writes_seen - ws, 2);
    check("close_error", error, 0);
`endif

    for (int n = 0; n < 8; n++) begin
      int len = $urandom_range(1, 20);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(alph[$urandom_range(0, 10)]);
      q.push_back(8'h00);
      run(q, 0);
    end

    ws = writes_seen;
    run(str2q("+-><.,+-"), 1);
    check("rst_mid_writes", writes_seen - ws, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bf_prog_loader.md
BF_PROG_LOADER -- requirements
Module: bf_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, giving the program memory address width (2^ADDR_W bytes).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a pulse that begins a load session.
REQ-005 SHALL have port in_data, input, 8 bits: source byte (ASCII program text).
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port prog_addr, output, ADDR_W bits: program memory write address.
REQ-009 SHALL have port prog_data, output, 8 bits: program memory write data.
REQ-010 SHALL have port prog_we, output, 1 bit: program memory write strobe, one cycle per byte.
REQ-011 SHALL have port busy, output, 1 bit: a session is in progress.
REQ-012 SHALL have port done, output, 1 bit: the last session ended successfully.
REQ-013 SHALL have port error, output, 2 bits: 0 = none, 1 = unmatched ']', 2 = unclosed '[', 3 = overflow.
REQ-014 SHALL have port length, output, ADDR_W bits: count of command bytes stored by the last successful session.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, TERM, DONE and ERR.
REQ-016 SHALL treat start as follows:
- IDLE/DONE/ERR + start -> LOAD; write pointer, depth, done and error cleared.
- start in LOAD/TERM is ignored.
REQ-017 SHALL drive in_ready=1 only in LOAD; a byte is accepted on in_valid & in_ready.
REQ-018 SHALL, for an accepted command byte (0x2B, 0x2D, 0x3C, 0x3E, 0x2E, 0x2C, 0x5B, 0x5D), present prog_we=1 with prog_addr=pointer and prog_data=byte on the next cycle, then increment the pointer.
REQ-019 SHALL drop accepted non-command, non-zero bytes (comments) with no write.
REQ-020 SHALL treat accepted 0x00 as end of text: LOAD -> TERM.
REQ-021 SHALL, in TERM, write 0x00 at the pointer for one cycle, set length=pointer and go to DONE.
REQ-022 SHALL, if a command is accepted while pointer = 2^ADDR_W-1 (last slot reserved for the terminator), write nothing and go to ERR with error=3.
REQ-023 SHALL hold the FSM in DONE (done=1, busy=0) or ERR (error kept, busy=0) until start or reset.
REQ-024 SHALL wrap no counter; overflow is always reported via REQ-022.
REQ-025 SHALL keep all outputs registered; prog_we is never asserted outside LOAD/TERM.

Reset
REQ-026 SHALL, on reset (which overrides start and in_valid in the same cycle), go to IDLE with in_ready=0, prog_we=0, prog_addr=0, prog_data=0, busy=0, done=0, error=0, length=0.
REQ-027 SHALL, on reset mid-session, abort immediately with no further writes.

Configuration
REQ-028 SHALL, with BF_LOADER_BRACKET_CHECK_EN defined, keep an ADDR_W-bit depth counter:
- '[' increments it.
- ']' at depth 0 -> ERR, error=1, no write; otherwise decrements it.
- 0x00 with depth != 0 -> ERR, error=2, no terminator write.
REQ-029 SHALL, without BF_LOADER_BRACKET_CHECK_EN, contain no depth logic and never report error codes 1 or 2.

Structure
REQ-030 SHALL place the FSM state encoding, the error-code constants and the eight command byte constants in the shared package bf_pkg.
REQ-031 SHALL use one sub-module, bf_cmd_classify: combinational byte -> is_cmd, is_open, is_close.

Verification
REQ-032 SHALL check: start, then stream "+[.+]>-[.-]" followed by 0x00 -> writes 2B 5B 2E 2B 5D 3E 2D 5B 2E 2D 5D at addresses 0..A, 00 at B; done=1, length=11.
REQ-033 SHALL check: stream "+ a\n-" followed by 0x00 -> exactly 3 writes (2B, 2D, 00), length=2.
REQ-034 SHALL check, with the macro defined: "]" -> error=1, no write; "[+" then 0x00 -> error=2, no terminator write.
REQ-035 SHALL check: 15 '+' then a 16th '+' with ADDR_W=4 -> 15 writes, then error=3, in_ready=0.
REQ-036 SHALL check: in_valid toggling randomly (backpressure) and reset asserted after 3 accepted bytes -> all outputs at reset values next cycle, and no prog_we thereafter until start.
